// File: rtl/mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_pkg : shared op/command codes and FSM states for mac_host      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mac_pkg;

  localparam int MAC_WIDTH = 16;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] CMD_CLR   = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_ACC   = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TURN_IN  = 3'd1,
    ST_PULSE_LO = 3'd2,
    ST_PULSE_HI = 3'd3,
    ST_TAIL     = 3'd4,
    ST_TURN_OUT = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_host_phase.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_host_phase : divide-by-CLK_DIV low/high phase generator        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mac_host_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic go_hi,
  output logic lo_start,
  output logic lo_last,
  output logic hi_last,
  output logic mac_clk
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          hi_q, hi_d;
  logic          wrap;

  assign wrap = (div_q == DIV_LAST);

  // A low phase is followed by a high phase only when the FSM asks for one.
  always_comb begin
    div_d = '0;
    hi_d  = 1'b0;
    if (en) begin
      div_d = wrap ? '0 : div_q + 1'b1;
      hi_d  = wrap ? (!hi_q && go_hi) : hi_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      hi_q  <= hi_d;
    end
  end

  assign lo_start = en && !hi_q && (div_q == '0);
  assign lo_last  = en && !hi_q && wrap;
  assign hi_last  = en &&  hi_q && wrap;
  assign mac_clk  = hi_q;

endmodule
`default_nettype wire

// File: rtl/mac_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_host : word-level host initiator for the bit-serial MAC slave  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mac_host
  import mac_pkg::*;
#(
  parameter int WIDTH   = MAC_WIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic [1:0]         mac_cmd,
  output logic               mac_clk,
  output logic               mac_io_out,
  output logic               mac_io_oe,
  input  logic               mac_io_in
);

  localparam int         AW    = 2 * WIDTH;
  localparam logic [5:0] NBITS = 6'(AW);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [AW-1:0]   shift_q, shift_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            io_out_q, io_out_d;
  logic            oe_q, oe_d;
  logic [AW-1:0]   result_q, result_d;
  logic            valid_q, valid_d;
  logic [1:0]      sync_q, sync_d;

  logic lo_start, lo_last, hi_last;

  mac_host_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state_q != ST_IDLE),
    .go_hi    (state_q == ST_PULSE_LO),
    .lo_start (lo_start),
    .lo_last  (lo_last),
    .hi_last  (hi_last),
    .mac_clk  (mac_clk)
  );

  always_comb begin
    sync_d   = {sync_q[0], mac_io_in};
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    cmd_d    = cmd_q;
    io_out_d = io_out_q;
    oe_d     = oe_q;
    result_d = result_q;
    valid_d  = 1'b0;

    // cnt holds the number of pulses begun, so at hi_last it includes the current one.
    if (lo_start && state_q == ST_PULSE_LO) cnt_d = cnt_q + 6'd1;

    case (state_q)
      ST_IDLE: begin
        if (start && op != OP_RSVD) begin
          op_d     = op;
          cnt_d    = '0;
          io_out_d = 1'b0;
          case (op)
            OP_CLR: begin
              state_d = ST_PULSE_LO;
              cmd_d   = CMD_CLR;
            end
            OP_MAC: begin
              state_d  = ST_PULSE_LO;
              cmd_d    = CMD_SHIFT;
              shift_d  = {a_in, b_in};
              io_out_d = b_in[0];
            end
            default: begin
              state_d = ST_TURN_IN;
              oe_d    = 1'b0;
              shift_d = '0;
            end
          endcase
        end
      end
      ST_TURN_IN: begin
        if (lo_last) begin
          state_d = ST_PULSE_LO;
          cmd_d   = CMD_READ;
        end
      end
      ST_PULSE_LO: begin
        if (lo_last) begin
          state_d = ST_PULSE_HI;
          if (op_q == OP_READ) shift_d = {shift_q[AW-2:0], sync_q[1]};
        end
      end
      ST_PULSE_HI: begin
        if (hi_last) begin
          state_d = ST_PULSE_LO;
          if (op_q == OP_MAC && cnt_q < NBITS) begin
            shift_d  = shift_q >> 1;
            io_out_d = shift_q[1];
          end else if (op_q == OP_MAC && cnt_q == NBITS) begin
            cmd_d    = CMD_ACC;
            io_out_d = 1'b0;
          end else if (op_q == OP_READ && cnt_q == NBITS) begin
            state_d = ST_TURN_OUT;
            cmd_d   = CMD_SHIFT;
          end else if (op_q != OP_READ) begin
            state_d = ST_TAIL;
            cmd_d   = CMD_SHIFT;
          end
        end
      end
      ST_TAIL: begin
        if (lo_last) state_d = ST_IDLE;
      end
      ST_TURN_OUT: begin
        if (lo_last) begin
          state_d  = ST_IDLE;
          oe_d     = 1'b1;
          result_d = shift_q;
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_CLR;
      cnt_q    <= '0;
      shift_q  <= '0;
      cmd_q    <= CMD_SHIFT;
      io_out_q <= 1'b0;
      oe_q     <= 1'b1;
      result_q <= '0;
      valid_q  <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      cmd_q    <= cmd_d;
      io_out_q <= io_out_d;
      oe_q     <= oe_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign mac_cmd      = cmd_q;
  assign mac_io_out   = io_out_q;
  assign mac_io_oe    = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mac_host : scoreboard bench for mac_host with a MAC slave model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mac_host;
  import mac_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        ready;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  mac_cmd;
  logic        mac_clk;
  logic        mac_io_out;
  logic        mac_io_oe;
  logic        mac_io_in;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_acc = '0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          pulse_cnt = 0;
  int          valid_cnt = 0;
  int          prot_err = 0;
  logic [3:0]  first_bits = '0;
  logic [1:0]  prev_cmd = 2'b01;

  always #5 clk = ~clk;

  mac_host #(.WIDTH(16), .CLK_DIV(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid),
    .mac_cmd      (mac_cmd),
    .mac_clk      (mac_clk),
    .mac_io_out   (mac_io_out),
    .mac_io_oe    (mac_io_oe),
    .mac_io_in    (mac_io_in)
  );

  // Behavioural slave: shifts in LSB-first to the top of sr, rotates C on reads.
  logic [31:0] sl_c = '0;
  logic [31:0] sl_sr = '0;
  always @(posedge mac_clk) begin
    case (mac_cmd)
      2'b00: sl_c <= '0;
      2'b01: sl_sr <= {mac_io_out, sl_sr[31:1]};
      2'b10: sl_c <= sl_c + 32'(sl_sr[31:16]) * 32'(sl_sr[15:0]);
      default: sl_c <= {sl_c[30:0], sl_c[31]};
    endcase
  end
  assign mac_io_in = mac_io_oe ? mac_io_out : ((mac_cmd == 2'b11) ? sl_c[31] : 1'b1);

  always @(posedge mac_clk) begin
    if (pulse_cnt < 4) first_bits[pulse_cnt[1:0]] = mac_io_out;
    pulse_cnt++;
  end

  always @(negedge clk) begin
    if (result_valid) begin
      obs_q.push_back(result);
      valid_cnt++;
    end
    if (reset_n) begin
      if (mac_cmd == CMD_READ && mac_io_oe) prot_err++;
      if (mac_cmd != prev_cmd && mac_clk) prot_err++;
      if (ready && (mac_clk || mac_cmd != CMD_SHIFT)) prot_err++;
    end
    prev_cmd = mac_cmd;
  end

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int busy);
    pulse_cnt  = 0;
    first_bits = '0;
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    case (o)
      OP_CLR:  exp_acc = '0;
      OP_MAC:  exp_acc = exp_acc + 32'(a) * 32'(b);
      OP_READ: exp_q.push_back(exp_acc);
      default: ;
    endcase
    busy = 0;
    while (busy < 400) begin
      @(negedge clk);
      if (ready) break;
      busy++;
    end
    checks++;
    if (busy >= 400) begin
      failures++;
      $display("FAIL op_timeout op=%0d busy=%0d required<400", o, busy);
    end
  endtask

  task automatic test_reset();
    int busy;
    int v0;
    logic [31:0] e, g;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
    checks++; if (mac_cmd !== 2'b01) begin failures++; $display("FAIL rst_cmd got=%b exp=01", mac_cmd); end
    checks++; if (mac_clk !== 1'b0) begin failures++; $display("FAIL rst_mac_clk got=%b exp=0", mac_clk); end
    checks++; if (mac_io_out !== 1'b0) begin failures++; $display("FAIL rst_io_out got=%b exp=0", mac_io_out); end
    checks++; if (mac_io_oe !== 1'b1) begin failures++; $display("FAIL rst_oe got=%b exp=1", mac_io_oe); end
    reset_n = 1'b1;
    @(negedge clk);
    v0 = valid_cnt;
    run_op(OP_CLR, 16'd0, 16'd0, busy);
    checks++; if (busy != 3 * D) begin failures++; $display("FAIL clr_busy got=%0d exp=%0d", busy, 3 * D); end
    checks++; if (pulse_cnt != 1) begin failures++; $display("FAIL clr_pulses got=%0d exp=1", pulse_cnt); end
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL rst_valid_pulses got=%0d exp=1", valid_cnt - v0); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_sb_size got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rst_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic_mac();
    int busy;
    logic [31:0] e, g;
    run_op(OP_CLR, 16'd0, 16'd0, busy);
    run_op(OP_MAC, 16'd3, 16'd5, busy);
    checks++; if (pulse_cnt != 33) begin failures++; $display("FAIL mac_pulses got=%0d exp=33", pulse_cnt); end
    checks++; if (first_bits !== 4'b0101) begin failures++; $display("FAIL mac_first_bits got=%b exp=0101", first_bits); end
    checks++; if (busy != 67 * D) begin failures++; $display("FAIL mac_busy got=%0d exp=%0d", busy, 67 * D); end
    run_op(OP_READ, 16'd0, 16'd0, busy);
    checks++; if (busy != 66 * D) begin failures++; $display("FAIL read_busy got=%0d exp=%0d", busy, 66 * D); end
    checks++; if (pulse_cnt != 32) begin failures++; $display("FAIL read_pulses got=%0d exp=32", pulse_cnt); end
    #1;
    checks++; if (result !== 32'd15) begin failures++; $display("FAIL mac_result got=%0d exp=15", result); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL mac_sb_size got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL mac_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    int busy;
    logic [31:0] e, g;
    run_op(OP_CLR, 16'd0, 16'd0, busy);
    run_op(OP_MAC, 16'hFFFF, 16'hFFFF, busy);
    run_op(OP_MAC, 16'hFFFF, 16'hFFFF, busy);
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    checks++; if (result !== 32'hFFFC0002) begin failures++; $display("FAIL ovf_read1 got=%h exp=FFFC0002", result); end
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    checks++; if (result !== 32'hFFFC0002) begin failures++; $display("FAIL ovf_read2 got=%h exp=FFFC0002", result); end
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin failures++; $display("FAIL ovf_sb_size got=%0d exp=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL ovf_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ignored();
    int busy;
    int v0;
    int nr;
    logic [31:0] r0, e, g;
    v0 = valid_cnt; r0 = result;
    pulse_cnt = 0;
    op = OP_MAC; a_in = 16'd4; b_in = 16'd6; start = 1'b1;
    @(posedge clk); #1;
    exp_acc = exp_acc + 32'd24;
    op = OP_READ;
    busy = 0;
    while (busy < 400) begin
      @(negedge clk);
      if (ready) break;
      busy++;
      if (busy == 20) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (busy != 67 * D) begin failures++; $display("FAIL ign_busy got=%0d exp=%0d", busy, 67 * D); end
    checks++; if (pulse_cnt != 33) begin failures++; $display("FAIL ign_pulses got=%0d exp=33", pulse_cnt); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL ign_valid got=%0d exp=%0d", valid_cnt, v0); end
    pulse_cnt = 0;
    op = OP_RSVD; start = 1'b1;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ready) nr++;
    end
    start = 1'b0;
    checks++; if (nr != 0) begin failures++; $display("FAIL rsvd_busy got=%0d exp=0", nr); end
    checks++; if (pulse_cnt != 0) begin failures++; $display("FAIL rsvd_pulses got=%0d exp=0", pulse_cnt); end
    checks++; if (result !== r0) begin failures++; $display("FAIL rsvd_result got=%h exp=%h", result, r0); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL rsvd_valid got=%0d exp=%0d", valid_cnt, v0); end
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL ign_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    int busy;
    pulse_cnt = 0;
    exp_acc = '0;
    op = OP_CLR; start = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ready) n++;
      else if (n > 0) break;
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_reaccept got=%b exp=0", ready); end
    checks++; if (n != 3 * D) begin failures++; $display("FAIL b2b_busy got=%0d exp=%0d", n, 3 * D); end
    busy = 0;
    while (busy < 100 && !ready) begin
      @(negedge clk);
      busy++;
    end
    checks++; if (!ready || pulse_cnt != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt); end
  endtask

  task automatic test_random();
    int busy;
    logic [1:0] o;
    logic [31:0] e, g;
    run_op(OP_CLR, 16'd0, 16'd0, busy);
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 2));
      run_op(o, 16'($urandom), 16'($urandom), busy);
    end
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_sb_size got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rnd_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int busy;
    int i;
    logic [31:0] e, g;
    pulse_cnt = 0;
    op = OP_MAC; a_in = 16'h1234; b_in = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while (i < 500 && pulse_cnt < 10) begin
      @(negedge clk);
      i++;
    end
    checks++; if (pulse_cnt < 10) begin failures++; $display("FAIL mid_reach_pulse10 got=%0d exp=10", pulse_cnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mac_clk !== 1'b0) begin failures++; $display("FAIL mid_mac_clk got=%b exp=0", mac_clk); end
    checks++; if (mac_cmd !== 2'b01) begin failures++; $display("FAIL mid_cmd got=%b exp=01", mac_cmd); end
    checks++; if (ready !== 1'b1 || mac_io_oe !== 1'b1 || mac_io_out !== 1'b0) begin
      failures++; $display("FAIL mid_ctrl got=%b%b%b exp=110", ready, mac_io_oe, mac_io_out);
    end
    checks++; if (result !== 32'h0 || result_valid !== 1'b0) begin failures++; $display("FAIL mid_result got=%h exp=0", result); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(OP_CLR, 16'd0, 16'd0, busy);
    run_op(OP_MAC, 16'd2, 16'd7, busy);
    run_op(OP_READ, 16'd0, 16'd0, busy);
    #1;
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL mid_after got=%0d exp=14", result); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL mid_read got=%h exp=%h", g, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_protocol();
    checks++;
    if (prot_err != 0) begin failures++; $display("FAIL protocol_violations got=%0d exp=0", prot_err); end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_overflow();
    test_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
